// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and constants for the iterative multiply/divide engine.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int ITERATIONS = 32;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

  // Magnitude of a two's-complement operand; unsigned operands pass through.
  function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
    logic [31:0] r;
    if (isSigned && v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 64-bit accumulator: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              isDiv,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              bitIn,
  output logic [2*XLEN-1:0] accNext
);

  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   shifted_s;
  logic [XLEN-1:0] diff_s;
  logic            noBorrow_s;

  // Divide keeps remainder in the upper half and shifts quotient bits into the lower half.
  always_comb begin
    sum_s      = {(XLEN+1){1'b0}};
    shifted_s  = {(XLEN+1){1'b0}};
    diff_s     = {XLEN{1'b0}};
    noBorrow_s = 1'b0;
    accNext    = acc;
    if (isDiv) begin
      shifted_s  = {acc[2*XLEN-1:XLEN], bitIn};
      noBorrow_s = (shifted_s >= {1'b0, operand});
      diff_s     = shifted_s[XLEN-1:0] - operand;
      if (noBorrow_s) begin
        accNext = {diff_s, acc[XLEN-2:0], 1'b1};
      end else begin
        accNext = {shifted_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      if (bitIn) begin
        sum_s = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
      end else begin
        sum_s = {1'b0, acc[2*XLEN-1:XLEN]};
      end
      accNext = {sum_s, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing HI/LO; Busy stalls the pipeline.
// Optional MULDIV_ZERO_BYPASS_EN: zero operands / zero divisor finish right after the start edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo
);

  localparam int IDX_W = $clog2(XLEN);

  state_t            state_r;
  logic              isDiv_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN-1:0]   absA_r;
  logic [XLEN-1:0]   absB_r;
  logic [2*XLEN-1:0] acc_r;
  logic              qNeg_r;
  logic              rNeg_r;
  logic              divZero_r;

  logic              isSigned_s;
  logic [IDX_W-1:0]  bitIdx_s;
  logic [XLEN-1:0]   stepOperand_s;
  logic              stepBit_s;
  logic [2*XLEN-1:0] accNext_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fixHi_s;
  logic [XLEN-1:0]   fixLo_s;

  assign isSigned_s = (Op == OP_MULT) || (Op == OP_DIV);

  // Multiply walks the multiplier LSB first; divide feeds dividend bits MSB first.
  always_comb begin
    bitIdx_s      = {IDX_W{1'b0}};
    stepOperand_s = {XLEN{1'b0}};
    stepBit_s     = 1'b0;
    if (isDiv_r) begin
      bitIdx_s      = ~cnt_r[IDX_W-1:0];
      stepOperand_s = absB_r;
      stepBit_s     = absA_r[bitIdx_s];
    end else begin
      bitIdx_s      = cnt_r[IDX_W-1:0];
      stepOperand_s = absA_r;
      stepBit_s     = absB_r[bitIdx_s];
    end
  end

  muldiv_step #(.XLEN(XLEN)) uStep (
    .isDiv   (isDiv_r),
    .acc     (acc_r),
    .operand (stepOperand_s),
    .bitIn   (stepBit_s),
    .accNext (accNext_s)
  );

  // Sign fixup of the unsigned magnitude result.
  always_comb begin
    prod_s  = {(2*XLEN){1'b0}};
    fixHi_s = {XLEN{1'b0}};
    fixLo_s = {XLEN{1'b0}};
    if (isDiv_r) begin
      if (rNeg_r) begin
        fixHi_s = {XLEN{1'b0}} - acc_r[2*XLEN-1:XLEN];
      end else begin
        fixHi_s = acc_r[2*XLEN-1:XLEN];
      end
      if (divZero_r) begin
        fixLo_s = DIV_ZERO_QUOT;
      end else if (qNeg_r) begin
        fixLo_s = {XLEN{1'b0}} - acc_r[XLEN-1:0];
      end else begin
        fixLo_s = acc_r[XLEN-1:0];
      end
    end else begin
      if (qNeg_r) begin
        prod_s = {(2*XLEN){1'b0}} - acc_r;
      end else begin
        prod_s = acc_r;
      end
      fixHi_s = prod_s[2*XLEN-1:XLEN];
      fixLo_s = prod_s[XLEN-1:0];
    end
  end

`ifdef MULDIV_ZERO_BYPASS_EN
  logic bypass_s;

  // Trivial operands whose result is known without iterating.
  always_comb begin
    if (Op[1]) begin
      bypass_s = (B == {XLEN{1'b0}});
    end else begin
      bypass_s = (A == {XLEN{1'b0}}) || (B == {XLEN{1'b0}});
    end
  end
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= IDLE;
      isDiv_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      absA_r    <= {XLEN{1'b0}};
      absB_r    <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      qNeg_r    <= 1'b0;
      rNeg_r    <= 1'b0;
      divZero_r <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Hi        <= {XLEN{1'b0}};
      Lo        <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (Start && !Flush) begin
            isDiv_r   <= Op[1];
            absA_r    <= absVal(A, isSigned_s);
            absB_r    <= absVal(B, isSigned_s);
            qNeg_r    <= isSigned_s & (A[XLEN-1] ^ B[XLEN-1]);
            rNeg_r    <= isSigned_s & A[XLEN-1];
            divZero_r <= (B == {XLEN{1'b0}});
            acc_r     <= {(2*XLEN){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            Busy      <= 1'b1;
`ifdef MULDIV_ZERO_BYPASS_EN
            if (bypass_s) begin
              Hi      <= Op[1] ? A : {XLEN{1'b0}};
              Lo      <= Op[1] ? DIV_ZERO_QUOT : {XLEN{1'b0}};
              Done    <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= CALC;
            end
`else
            state_r   <= CALC;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (Flush) begin
            Busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            acc_r <= accNext_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(ITERATIONS - 1)) begin
              state_r <= FIX;
            end else begin
              state_r <= CALC;
            end
          end
        end
        FIX: begin
          if (Flush) begin
            Busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            Hi      <= fixHi_s;
            Lo      <= fixLo_s;
            Done    <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int          numCompared;
  int          numMismatched;
  logic [31:0] lastHi;
  logic [31:0] lastLo;

`ifdef MULDIV_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 33;
`endif

  muldiv_unit dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Flush (Flush),
    .Busy  (Busy),
    .Done  (Done),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Launch one operation and check latency, Busy coverage and the HI/LO result.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input int expLat);
    int   n;
    logic busyDropped;
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    checkVal({tag, "_busyE0"}, {31'd0, Busy}, 32'd1);
    n           = 0;
    busyDropped = 1'b0;
    while (!Done && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
      if (!Busy) busyDropped = 1'b1;
    end
    checkVal({tag, "_latency"}, n, expLat);
    checkVal({tag, "_busyHeld"}, {31'd0, busyDropped}, 32'd0);
    checkVal({tag, "_hi"}, Hi, expHi);
    checkVal({tag, "_lo"}, Lo, expLo);
    @(posedge Clk);
    #1;
    checkVal({tag, "_doneDrop"}, {31'd0, Done}, 32'd0);
    checkVal({tag, "_busyDrop"}, {31'd0, Busy}, 32'd0);
    lastHi = expHi;
    lastLo = expLo;
  endtask

  initial begin
    int doneCnt;
    numCompared   = 0;
    numMismatched = 0;
    Rst   = 1'b1;
    Start = 1'b0;
    Flush = 1'b0;
    Op    = 2'b00;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    checkVal("rst_busy", {31'd0, Busy}, 32'd0);
    checkVal("rst_done", {31'd0, Done}, 32'd0);
    checkVal("rst_hi", Hi, 32'd0);
    checkVal("rst_lo", Lo, 32'd0);
    Rst = 1'b0;

    runOp("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 33);
    runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    runOp("mult_min_x2", 2'b00, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 33);
    runOp("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    runOp("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    runOp("divu_100_7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 33);
    runOp("divu_by0", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, ZERO_LAT);

    // Start and Flush together in IDLE: the Start is dropped.
    @(negedge Clk);
    Start = 1'b1;
    Flush = 1'b1;
    Op    = 2'b11;
    A     = 32'd9;
    B     = 32'd3;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Flush = 1'b0;
    checkVal("startflush_busy", {31'd0, Busy}, 32'd0);

    // Flush mid-CALC: no Done, result registers untouched.
    @(negedge Clk);
    Start = 1'b1;
    Op    = 2'b00;
    A     = 32'd3;
    B     = 32'd5;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Flush = 1'b1;
    checkVal("flush_hiMidCalc", Hi, lastHi);
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    checkVal("flush_busy", {31'd0, Busy}, 32'd0);
    doneCnt = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done) doneCnt++;
    end
    checkVal("flush_noDone", doneCnt, 32'd0);
    checkVal("flush_hi", Hi, lastHi);
    checkVal("flush_lo", Lo, lastLo);

    // Start pulsed at E5 is ignored.
    @(negedge Clk);
    Start = 1'b1;
    Op    = 2'b11;
    A     = 32'd100;
    B     = 32'd7;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Start = 1'b1;
    A     = 32'd5;
    B     = 32'd1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    doneCnt = 0;
    repeat (70) begin
      @(posedge Clk);
      #1;
      if (Done) doneCnt++;
    end
    checkVal("ignStart_doneCount", doneCnt, 32'd1);
    checkVal("ignStart_hi", Hi, 32'h00000002);
    checkVal("ignStart_lo", Lo, 32'h0000000E);

    // Rst at E20 of a DIV clears everything.
    @(negedge Clk);
    Start = 1'b1;
    Op    = 2'b10;
    A     = 32'hFFFFFFF9;
    B     = 32'd2;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (19) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    checkVal("midRst_busy", {31'd0, Busy}, 32'd0);
    checkVal("midRst_done", {31'd0, Done}, 32'd0);
    checkVal("midRst_hi", Hi, 32'd0);
    checkVal("midRst_lo", Lo, 32'd0);

    runOp("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
